// File: rtl/regs_writer_if.sv
// Write-command channel into the register writer: valid/ready handshake
// carrying {op, select, data}.
interface regs_writer_if #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
);
  localparam int SELW = $clog2(NREGS);

  logic             iWVALID;
  logic             oWREADY;
  logic [1:0]       iWOP;
  logic [SELW-1:0]  iWSELECT;
  logic [WIDTH-1:0] iWDATA;

  modport master (output iWVALID, iWOP, iWSELECT, iWDATA, input oWREADY);
  modport slave  (input iWVALID, iWOP, iWSELECT, iWDATA, output oWREADY);
endinterface

// File: rtl/regs_writer.sv
// Register bank writer: queues LOAD/ADD/CLR/NOP commands in a small FIFO and
// applies them to an NREGS x WIDTH bank; CLR walks the bank one register per edge.
module regs_writer #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  parameter int DEPTH = 2
) (
  input  logic             iCLK,
  input  logic             iRST,
  regs_writer_if.slave     w,
  output logic [WIDTH-1:0] oREGS [0:NREGS-1],
  output logic             oBUSY,
  output logic             oDONE
);
  localparam int SELW = $clog2(NREGS);
  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {OP_LOAD, OP_ADD, OP_CLR, OP_NOP} op_e;
  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  typedef struct packed {
    op_e              op;
    logic [SELW-1:0]  sel;
    logic [WIDTH-1:0] data;
  } cmd_t;

  // ---------------------------------------------------------------- FIFO
  cmd_t            fifo_q [DEPTH];
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            push, pop;
  cmd_t            head;

  assign w.oWREADY = (count_q != CNTW'(DEPTH));
  assign push      = w.iWVALID && w.oWREADY;
  assign head      = fifo_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTRW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTRW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge iCLK) begin
    if (push) fifo_q[wr_ptr_q] <= cmd_t'{op: op_e'(w.iWOP), sel: w.iWSELECT, data: w.iWDATA};
  end

  // ------------------------------------------------------ sequencer/bank
  state_e                      state_q, state_d;
  logic [SELW-1:0]             clr_cnt_q, clr_cnt_d;
  logic [NREGS-1:0][WIDTH-1:0] regs_q, regs_d;
  logic                        done_q, done_d;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    regs_d    = regs_q;
    done_d    = 1'b0;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop = 1'b1;
          case (head.op)
            OP_LOAD: begin
              regs_d[head.sel] = head.data;
              done_d           = 1'b1;
            end
            OP_ADD: begin
              regs_d[head.sel] = regs_q[head.sel] + head.data;
              done_d           = 1'b1;
            end
            OP_CLR: begin
              regs_d[0] = '0;
              clr_cnt_d = SELW'(1);
              state_d   = S_CLEAR;
            end
            default: done_d = 1'b1;
          endcase
        end
      end
      S_CLEAR: begin
        regs_d[clr_cnt_q] = '0;
        clr_cnt_d         = clr_cnt_q + SELW'(1);
        // CLR completes only once the last register has been zeroed.
        if (clr_cnt_q == SELW'(NREGS - 1)) begin
          clr_cnt_d = '0;
          state_d   = S_IDLE;
          done_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q   <= S_IDLE;
      clr_cnt_q <= '0;
      regs_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      regs_q    <= regs_d;
      done_q    <= done_d;
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_out
    assign oREGS[g] = regs_q[g];
  end

  assign oBUSY = (count_q != '0) || (state_q != S_IDLE);
  assign oDONE = done_q;
endmodule

// File: doc/regs_writer.md
Name: regs_writer

Overview:
- Write-side counterpart to the BPF datapath's 4:1 register read mux.
- Owns a 4 x 8-bit register bank and applies queued write commands (load, add, clear-all, nop) accepted over a valid/ready handshake.
- Exposes the bank as an unpacked array that feeds the read mux's iREGS input directly.
- Contains a small command FIFO and a multi-cycle clear sequencer.

Parameters:
- WIDTH, 8, register data width.
- NREGS, 4, number of registers; select width = 2.
- DEPTH, 2, command FIFO depth (power of two).

Ports:
- iCLK  input  1  clock; all state updates on the rising edge.
- iRST  input  1  reset, asynchronous, active-high.
- iWVALID  input  1  command valid.
- oWREADY  output  1  command can be accepted this cycle.
- iWOP  input  2  0=LOAD, 1=ADD, 2=CLR (clear all), 3=NOP.
- iWSELECT  input  2  target register index (ignored for CLR and NOP).
- iWDATA  input  WIDTH  operand (ignored for CLR and NOP).
- oREGS  output  [WIDTH-1:0] x [0:NREGS-1]  register bank contents.
- oBUSY  output  1  FIFO non-empty or sequencer not IDLE.
- oDONE  output  1  one-cycle pulse when a command completes.

Behaviour:
- Reset (async, iRST=1):
  - oREGS all 0x00, FIFO empty, FSM IDLE, clear counter 0.
  - oDONE=0, oBUSY=0, oWREADY=1 once iRST deasserts.
  - Reset mid-CLR or with queued commands discards all pending work.
- Handshake:
  - Accept on the edge where iWVALID && oWREADY; the {op, sel, data} tuple is pushed into the FIFO.
  - oWREADY = !full, combinational from the FIFO count.
  - A push and a pop in the same cycle are both legal when not full; count is unchanged.
  - With oWREADY=0, iWVALID is ignored and the command is not lost; the master holds it.
- FSM states: IDLE, CLEAR.
- IDLE with FIFO non-empty: pop the head on this edge and execute:
  - LOAD: regs[sel] <= data.
  - ADD: regs[sel] <= (regs[sel] + data) mod 2^WIDTH; carry discarded (0xF0 + 0x20 = 0x10).
  - NOP: no register change.
  - CLR: regs[0] <= 0, counter <= 1, go to CLEAR.
- CLEAR: each edge clears regs[counter] and increments counter.
  - When counter == NREGS-1, clear it and return to IDLE.
  - Total CLR occupancy: 4 edges. No pops during CLEAR; the FIFO still accepts pushes until full.
- Latency:
  - A command accepted at edge N with the FIFO empty and the FSM IDLE commits at edge N+1.
  - Throughput is one LOAD/ADD/NOP per cycle.
  - Back-to-back commands to the same register see the prior result; an ADD reads the value committed on the previous edge.
- oDONE:
  - Registered; asserted high for the cycle following the commit edge (visible together with the updated oREGS).
  - LOAD/ADD/NOP: pulses once per command.
  - CLR: pulses once, after regs[NREGS-1] is cleared.
- oBUSY: combinational, = (count != 0) || (state != IDLE).
- Full/empty:
  - Pop only when non-empty.
  - FIFO pointers wrap modulo DEPTH; count ranges 0..DEPTH.

Test Plan:
1. Reset, then LOAD sel=2 data=0x5A accepted at edge 0 -> oREGS[2]=0x5A and oDONE=1 after edge 1; other registers stay 0x00; oBUSY low after edge 1.
2. LOAD r1=0xF0, then ADD r1=0x20 on consecutive cycles -> r1=0xF0 after edge 1 and 0x10 after edge 2; two oDONE pulses.
3. Preload r0..r3 = 0x11,0x22,0x33,0x44, then CLR followed by LOAD r3=0x77 -> registers zeroed on successive edges 0,1,2,3; LOAD commits on the next edge (r3=0x77); oDONE pulses once for CLR and once for LOAD.
4. Hold iWVALID=1 with NOPs during CLR -> oWREADY drops after 2 accepts (FIFO full); no command is lost or duplicated; the count of oDONE pulses equals the count of accepted commands.
5. Assert iRST asynchronously mid-CLEAR with 2 queued commands -> oREGS=0 immediately; oBUSY=0, oDONE=0; the queued commands never execute.
6. Random mix of 1000 commands with random iWVALID gaps -> final oREGS matches a scoreboard model; oWREADY is never 1 while the FIFO is full.
